traffic_sig_controller_n: RTL and testbench

- Parametrised N-approach signal controller; next generation of the two-road highway/country controller.
- Serves approaches round-robin on latched vehicle demand.
- Counter-based minimum-green, maximum-green, yellow and all-red intervals.
- Rests in green on the current approach when no other demand exists. Sits at intersection top level; drives lamp decoders directly.

---
 rtl/traffic_sig_controller_n.sv | 153 +++++++++++++++
 tb/tb_traffic_sig_controller_n.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sig_controller_n.sv
// rtl/traffic_sig_controller_n.sv - N-approach round-robin traffic signal controller
// Latched per-approach demand, min/max green, yellow and all-red intervals; rests green without conflict.
module traffic_sig_controller_n #(
  parameter int N_APPR    = 4,
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int HOME      = 0,
  localparam int IDX_W    = $clog2(N_APPR)
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic [N_APPR-1:0]     car_req,
  output logic [2*N_APPR-1:0]   sig,
  output logic [IDX_W-1:0]      active_idx,
  output logic [1:0]            phase
);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_t;

  localparam logic [1:0] LAMP_RED    = 2'd0;
  localparam logic [1:0] LAMP_YELLOW = 2'd1;
  localparam logic [1:0] LAMP_GREEN  = 2'd2;

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] TMR_MAX  = '1;
  localparam logic [IDX_W-1:0] HOME_IDX = IDX_W'(HOME);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(N_APPR);
  localparam logic [2*N_APPR-1:0] SIG_HOME = (2*N_APPR)'(LAMP_GREEN) << (2*HOME);

  generate
    if (N_APPR < 2 || N_APPR > 16) begin : g_bad_n_appr
      $error("N_APPR must be in 2..16");
    end
    if (MIN_GREEN < 1 || YELLOW_T < 1 || ALLRED_T < 1) begin : g_bad_interval
      $error("MIN_GREEN, YELLOW_T and ALLRED_T must be >= 1");
    end
    if (MAX_GREEN < MIN_GREEN || MAX_GREEN >= (1 << CNT_W)) begin : g_bad_max_green
      $error("MAX_GREEN must be >= MIN_GREEN and < 2**CNT_W");
    end
    if (HOME < 0 || HOME >= N_APPR) begin : g_bad_home
      $error("HOME must index an existing approach");
    end
  endgenerate

  phase_t                ph_q, ph_d;
  logic [IDX_W-1:0]      act_q, act_d;
  logic [CNT_W-1:0]      tmr_q, tmr_d;
  logic [N_APPR-1:0]     pend_q, pend_d;
  logic [2*N_APPR-1:0]   sig_q, sig_d;

  logic [N_APPR-1:0]     act_mask;
  logic [N_APPR-1:0]     green_mask;
  logic                  conflict;
  logic [IDX_W:0]        cand;
  logic                  nxt_found;
  logic [IDX_W-1:0]      nxt_idx;
  logic [1:0]            lamp_d;

  always_comb begin
    act_mask          = '0;
    act_mask[act_q]   = 1'b1;
    green_mask        = (ph_q == PH_GREEN) ? act_mask : '0;
    conflict          = |(pend_q & ~act_mask);

    // Round-robin search; the previous approach itself (k == N_APPR) is the last candidate.
    nxt_found = 1'b0;
    nxt_idx   = HOME_IDX;
    cand      = '0;
    for (int k = N_APPR; k >= 1; k--) begin
      cand = {1'b0, act_q} + (IDX_W+1)'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (pend_q[cand]) begin
        nxt_found = 1'b1;
        nxt_idx   = cand[IDX_W-1:0];
      end
    end

    ph_d   = ph_q;
    act_d  = act_q;
    tmr_d  = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 1'b1;
    pend_d = pend_q | (car_req & ~green_mask);

    case (ph_q)
      PH_GREEN: begin
        if (tmr_q >= MIN_LAST && conflict && (!car_req[act_q] || tmr_q >= MAX_LAST)) begin
          ph_d  = PH_YELLOW;
          tmr_d = '0;
        end
      end
      PH_YELLOW: begin
        if (tmr_q >= YEL_LAST) begin
          ph_d  = PH_ALLRED;
          tmr_d = '0;
        end
      end
      PH_ALLRED: begin
        if (tmr_q >= AR_LAST) begin
          ph_d          = PH_GREEN;
          act_d         = nxt_found ? nxt_idx : HOME_IDX;
          tmr_d         = '0;
          pend_d[act_d] = 1'b0;
        end
      end
      default: begin
        ph_d  = PH_GREEN;
        act_d = HOME_IDX;
        tmr_d = '0;
      end
    endcase

    case (ph_d)
      PH_GREEN:  lamp_d = LAMP_GREEN;
      PH_YELLOW: lamp_d = LAMP_YELLOW;
      default:   lamp_d = LAMP_RED;
    endcase

    sig_d = '0;
    for (int i = 0; i < N_APPR; i++) begin
      sig_d[2*i +: 2] = (act_d == IDX_W'(i)) ? lamp_d : LAMP_RED;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      ph_q   <= PH_GREEN;
      act_q  <= HOME_IDX;
      tmr_q  <= '0;
      pend_q <= '0;
      sig_q  <= SIG_HOME;
    end else begin
      ph_q   <= ph_d;
      act_q  <= act_d;
      tmr_q  <= tmr_d;
      pend_q <= pend_d;
      sig_q  <= sig_d;
    end
  end

  assign sig        = sig_q;
  assign active_idx = act_q;
  assign phase      = ph_q;

endmodule

// File: tb/tb_traffic_sig_controller_n.sv
// tb/tb_traffic_sig_controller_n.sv - directed bench for traffic_sig_controller_n
// Default 4-approach build plus a 2-approach, MIN_GREEN=1 build sharing clock and reset.
module tb_traffic_sig_controller_n;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic [3:0] car_req = '0;
  logic [7:0] sig;
  logic [1:0] active_idx;
  logic [1:0] phase;

  logic [1:0] car_req2 = '0;
  logic [3:0] sig2;
  logic [0:0] active2;
  logic [1:0] phase2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_sig_controller_n dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .car_req    (car_req),
    .sig        (sig),
    .active_idx (active_idx),
    .phase      (phase)
  );

  traffic_sig_controller_n #(.N_APPR(2), .MIN_GREEN(1)) dut2 (
    .clk        (clk),
    .clear_n    (clear_n),
    .car_req    (car_req2),
    .sig        (sig2),
    .active_idx (active2),
    .phase      (phase2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lamp_vec(input int a, input int ph);
    logic [31:0] v;
    v = '0;
    v[2*a +: 2] = (ph == 0) ? 2'd2 : (ph == 1) ? 2'd1 : 2'd0;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int sel, input int act, input int ph);
    int cnt;
    bit bad;
    if (sel == 0) begin
      check_eq({tag, "_phase"}, 32'(phase), 32'(ph));
      check_eq({tag, "_active"}, 32'(active_idx), 32'(act));
      check_eq({tag, "_sig"}, 32'(sig), lamp_vec(act, ph));
    end else begin
      check_eq({tag, "_phase"}, 32'(phase2), 32'(ph));
      check_eq({tag, "_active"}, 32'(active2), 32'(act));
      check_eq({tag, "_sig"}, 32'(sig2), lamp_vec(act, ph));
      cnt = 0;
      bad = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (sig2[2*i +: 2] != 2'd0) cnt++;
        if (sig2[2*i +: 2] == 2'd3) bad = 1'b1;
      end
      check_eq({tag, "_single"}, 32'(cnt <= 1 && !bad), 32'd1);
    end
  endtask

  task automatic expect_seq(input string tag, input int sel, input int act, input int ph, input int n);
    repeat (n) begin
      step();
      check_state(tag, sel, act, ph);
    end
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    clear_n = 1'b0;
    car_req = '0;
    step();
    step();
    clear_n = 1'b1;
  endtask

  initial begin
    // Reset then rest on HOME with no demand
    reset_dut();
    check_state("rst", 0, 0, 0);
    check_state("rst2", 1, 0, 0);
    expect_seq("s1_rest", 0, 0, 0, 100);

    // Single pulse on approach 2
    reset_dut();
    check_state("s2_rst", 0, 0, 0);
    step();
    check_state("s2_g0a", 0, 0, 0);
    car_req = 4'b0100;
    step();
    check_state("s2_g0b", 0, 0, 0);
    car_req = 4'b0000;
    expect_seq("s2_g0", 0, 0, 0, 2);
    expect_seq("s2_y0", 0, 0, 1, 3);
    expect_seq("s2_r0", 0, 0, 2, 2);
    expect_seq("s2_g2", 0, 2, 0, 10);

    // Held own demand: max green of 20 cycles
    reset_dut();
    car_req = 4'b0001;
    check_state("s3_rst", 0, 0, 0);
    step();
    check_state("s3_g0a", 0, 0, 0);
    car_req = 4'b0011;
    step();
    check_state("s3_g0b", 0, 0, 0);
    car_req = 4'b0001;
    expect_seq("s3_g0", 0, 0, 0, 17);
    expect_seq("s3_y0", 0, 0, 1, 3);
    expect_seq("s3_r0", 0, 0, 2, 2);
    step();
    check_state("s3_g1a", 0, 1, 0);
    car_req = 4'b0000;
    expect_seq("s3_g1", 0, 1, 0, 4);
    expect_seq("s3_y1", 0, 1, 1, 3);
    expect_seq("s3_r1", 0, 1, 2, 2);
    expect_seq("s3_g0back", 0, 0, 0, 1);

    // Round robin from active 1 with 0, 2, 3 pending together
    reset_dut();
    check_state("s4_rst", 0, 0, 0);
    step();
    car_req = 4'b0010;
    step();
    car_req = 4'b0000;
    expect_seq("s4_g0", 0, 0, 0, 2);
    expect_seq("s4_y0", 0, 0, 1, 3);
    expect_seq("s4_r0", 0, 0, 2, 2);
    step();
    check_state("s4_g1a", 0, 1, 0);
    car_req = 4'b1101;
    step();
    check_state("s4_g1b", 0, 1, 0);
    car_req = 4'b0000;
    expect_seq("s4_g1", 0, 1, 0, 3);
    expect_seq("s4_y1", 0, 1, 1, 3);
    expect_seq("s4_r1", 0, 1, 2, 2);
    expect_seq("s4_g2", 0, 2, 0, 5);
    expect_seq("s4_y2", 0, 2, 1, 3);
    expect_seq("s4_r2", 0, 2, 2, 2);
    expect_seq("s4_g3", 0, 3, 0, 5);
    expect_seq("s4_y3", 0, 3, 1, 3);
    expect_seq("s4_r3", 0, 3, 2, 2);
    expect_seq("s4_g0rest", 0, 0, 0, 10);

    // Async reset during yellow of approach 3 with 0 and 1 pending
    car_req = 4'b1000;
    step();
    check_state("s5_g0", 0, 0, 0);
    car_req = 4'b0000;
    expect_seq("s5_y0", 0, 0, 1, 3);
    expect_seq("s5_r0", 0, 0, 2, 2);
    step();
    check_state("s5_g3a", 0, 3, 0);
    car_req = 4'b0011;
    step();
    check_state("s5_g3b", 0, 3, 0);
    car_req = 4'b0000;
    expect_seq("s5_g3", 0, 3, 0, 3);
    step();
    check_state("s5_y3", 0, 3, 1);
    #2;
    clear_n = 1'b0;
    #1;
    check_state("s5_async", 0, 0, 0);
    #4;
    clear_n = 1'b1;
    step();
    check_state("s5_post_a", 0, 0, 0);
    car_req = 4'b0100;
    step();
    check_state("s5_post_b", 0, 0, 0);
    car_req = 4'b0000;
    expect_seq("s5_g0", 0, 0, 0, 2);
    expect_seq("s5_y0b", 0, 0, 1, 3);
    expect_seq("s5_r0b", 0, 0, 2, 2);
    expect_seq("s5_g2", 0, 2, 0, 5);

    // Two-approach build, min green 1, approach 1 demand held
    car_req2 = 2'b10;
    reset_dut();
    check_state("s6_rst", 1, 0, 0);
    expect_seq("s6_g0", 1, 0, 0, 1);
    expect_seq("s6_y0", 1, 0, 1, 3);
    expect_seq("s6_r0", 1, 0, 2, 2);
    expect_seq("s6_g1rest", 1, 1, 0, 30);
    car_req2 = 2'b11;
    step();
    check_state("s6_g1last", 1, 1, 0);
    car_req2 = 2'b10;
    expect_seq("s6_y1", 1, 1, 1, 3);
    expect_seq("s6_r1", 1, 1, 2, 2);
    expect_seq("s6_g0b", 1, 0, 0, 1);
    expect_seq("s6_y0b", 1, 0, 1, 3);
    expect_seq("s6_r0b", 1, 0, 2, 2);
    expect_seq("s6_g1b", 1, 1, 0, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
